sdf_radix2_stage: RTL and testbench



---
 rtl/sdf_radix2_stage_if.sv | 27 ++
 rtl/sdf_radix2_stage.sv | 119 +++++++++++
 tb/tb_sdf_radix2_stage.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/sdf_radix2_stage_if.sv
// Sample stream bundle for one SDF radix-2 stage: complex input stream in,
// butterfly/difference stream plus twiddle selection out.
interface sdf_radix2_stage_if #(
   parameter int WIDTH = 16,
   parameter int N     = 64
);
   logic                      in_valid;
   logic signed [WIDTH-1:0]   in_real;
   logic signed [WIDTH-1:0]   in_img;
   logic                      out_valid;
   logic signed [WIDTH-1:0]   out_real;
   logic signed [WIDTH-1:0]   out_img;
   logic                      out_tw_en;
   logic [$clog2(N)-1:0]      out_tw_idx;

   // The stage itself: consumes the input stream, produces the output stream.
   modport master (
      input  in_valid, in_real, in_img,
      output out_valid, out_real, out_img, out_tw_en, out_tw_idx
   );

   // The environment around the stage.
   modport slave (
      output in_valid, in_real, in_img,
      input  out_valid, out_real, out_img, out_tw_en, out_tw_idx
   );
endinterface

// File: rtl/sdf_radix2_stage.sv
// Radix-2 DIF single-path delay-feedback stage: emits butterfly sums directly and
// replays the buffered differences one half-frame later with their twiddle index.
module sdf_radix2_stage #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 32,
   parameter int N     = 64
) (
   input  logic                 clk,
   input  logic                 rst_n,
   sdf_radix2_stage_if.master   bus
);
   localparam int CW     = $clog2(2 * DEPTH);
   localparam int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int TW     = $clog2(N);
   localparam int STRIDE = N / (2 * DEPTH);

   typedef enum logic {
      PH_FILL = 1'b0,
      PH_BFLY = 1'b1
   } phase_e;

   logic [CW-1:0]           cnt_q, cnt_d;
   logic                    primed_q, primed_d;
   logic signed [WIDTH-1:0] line_re_q [DEPTH];
   logic signed [WIDTH-1:0] line_re_d [DEPTH];
   logic signed [WIDTH-1:0] line_im_q [DEPTH];
   logic signed [WIDTH-1:0] line_im_d [DEPTH];
   logic                    out_valid_q, out_valid_d;
   logic signed [WIDTH-1:0] out_re_q, out_re_d;
   logic signed [WIDTH-1:0] out_im_q, out_im_d;
   logic                    out_tw_en_q, out_tw_en_d;
   logic [TW-1:0]           out_tw_idx_q, out_tw_idx_d;

   phase_e                  phase;
   logic [AW-1:0]           j;
   logic signed [WIDTH-1:0] a_re, a_im;
   logic signed [WIDTH:0]   sum_re, sum_im, dif_re, dif_im;
   logic [TW-1:0]           tw_idx;

   // With DEPTH=1 the address has no bits; the mask pins it to entry 0.
   assign phase  = phase_e'(cnt_q[CW-1]);
   assign j      = cnt_q[AW-1:0] & AW'(DEPTH - 1);
   assign a_re   = line_re_q[j];
   assign a_im   = line_im_q[j];
   assign tw_idx = TW'(int'(j) * STRIDE);

   // One guard bit keeps the sum/difference exact before the halving shift.
   assign sum_re = (WIDTH+1)'(a_re) + (WIDTH+1)'(bus.in_real);
   assign sum_im = (WIDTH+1)'(a_im) + (WIDTH+1)'(bus.in_img);
   assign dif_re = (WIDTH+1)'(a_re) - (WIDTH+1)'(bus.in_real);
   assign dif_im = (WIDTH+1)'(a_im) - (WIDTH+1)'(bus.in_img);

   always_comb begin
      cnt_d        = cnt_q;
      primed_d     = primed_q;
      line_re_d    = line_re_q;
      line_im_d    = line_im_q;
      out_valid_d  = 1'b0;
      out_re_d     = out_re_q;
      out_im_d     = out_im_q;
      out_tw_en_d  = out_tw_en_q;
      out_tw_idx_d = out_tw_idx_q;
      if (bus.in_valid) begin
         cnt_d = cnt_q + 1'b1;
         case (phase)
            PH_FILL: begin
               line_re_d[j] = bus.in_real;
               line_im_d[j] = bus.in_img;
               out_re_d     = a_re;
               out_im_d     = a_im;
               out_tw_en_d  = 1'b1;
               out_tw_idx_d = tw_idx;
               out_valid_d  = primed_q;
            end
            PH_BFLY: begin
               line_re_d[j] = WIDTH'(dif_re >>> 1);
               line_im_d[j] = WIDTH'(dif_im >>> 1);
               out_re_d     = WIDTH'(sum_re >>> 1);
               out_im_d     = WIDTH'(sum_im >>> 1);
               out_tw_en_d  = 1'b0;
               out_tw_idx_d = '0;
               out_valid_d  = 1'b1;
               primed_d     = 1'b1;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q        <= '0;
         primed_q     <= 1'b0;
         line_re_q    <= '{default: '0};
         line_im_q    <= '{default: '0};
         out_valid_q  <= 1'b0;
         out_re_q     <= '0;
         out_im_q     <= '0;
         out_tw_en_q  <= 1'b0;
         out_tw_idx_q <= '0;
      end else begin
         cnt_q        <= cnt_d;
         primed_q     <= primed_d;
         line_re_q    <= line_re_d;
         line_im_q    <= line_im_d;
         out_valid_q  <= out_valid_d;
         out_re_q     <= out_re_d;
         out_im_q     <= out_im_d;
         out_tw_en_q  <= out_tw_en_d;
         out_tw_idx_q <= out_tw_idx_d;
      end
   end

   assign bus.out_valid  = out_valid_q;
   assign bus.out_real   = out_re_q;
   assign bus.out_img    = out_im_q;
   assign bus.out_tw_en  = out_tw_en_q;
   assign bus.out_tw_idx = out_tw_idx_q;
endmodule

// File: tb/tb_sdf_radix2_stage.sv
// Bench for sdf_radix2_stage at DEPTH=2, N=64: directed scenarios plus random
// streams checked against a frame-level butterfly model.
module tb_sdf_radix2_stage;
   localparam int WIDTH = 16;
   localparam int DEPTH = 2;
   localparam int N     = 64;
   localparam int FR    = 2 * DEPTH;

   logic clk;
   logic rst_n;
   int   checks;
   int   errors;

   sdf_radix2_stage_if #(.WIDTH(WIDTH), .N(N)) bus ();

   sdf_radix2_stage #(.WIDTH(WIDTH), .DEPTH(DEPTH), .N(N)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Frame-level model: first half of a frame is remembered, second half forms
   // sums/differences; differences come out during the next frame's first half.
   int m_pos;
   bit m_primed;
   int m_half_re [DEPTH];
   int m_half_im [DEPTH];
   int m_dif_re  [DEPTH];
   int m_dif_im  [DEPTH];
   int e_valid, e_re, e_im, e_tw, e_idx;

   function automatic int fdiv2(input int x);
      return (x - (((x % 2) != 0 && x < 0) ? 1 : 0)) / 2;
   endfunction

   task automatic model_reset();
      m_pos = 0;
      m_primed = 0;
      for (int i = 0; i < DEPTH; i++) begin
         m_half_re[i] = 0; m_half_im[i] = 0; m_dif_re[i] = 0; m_dif_im[i] = 0;
      end
      e_valid = 0; e_re = 0; e_im = 0; e_tw = 0; e_idx = 0;
   endtask

   task automatic step(input bit v, input int re, input int im);
      int k;
      bus.in_valid = v;
      bus.in_real  = WIDTH'(re);
      bus.in_img   = WIDTH'(im);
      @(posedge clk);
      #1;
      e_valid = 0;
      if (v) begin
         if (m_pos < DEPTH) begin
            e_valid = m_primed ? 1 : 0;
            e_re = m_dif_re[m_pos];
            e_im = m_dif_im[m_pos];
            e_tw = 1;
            e_idx = m_pos * (N / FR);
            m_half_re[m_pos] = re;
            m_half_im[m_pos] = im;
         end else begin
            k = m_pos - DEPTH;
            e_valid = 1;
            e_re = fdiv2(m_half_re[k] + re);
            e_im = fdiv2(m_half_im[k] + im);
            m_dif_re[k] = fdiv2(m_half_re[k] - re);
            m_dif_im[k] = fdiv2(m_half_im[k] - im);
            e_tw = 0;
            e_idx = 0;
            m_primed = 1;
         end
         m_pos = (m_pos + 1) % FR;
      end
   endtask

   task automatic do_reset();
      bus.in_valid = 1'b0;
      bus.in_real  = '0;
      bus.in_img   = '0;
      rst_n = 1'b0;
      model_reset();
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      do_reset();
      step(1, 1000, 0); step(1, 2000, 0); step(1, 3000, 0);
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_real !== 16'sd2000) begin
         errors++; $display("FAIL reset_pre valid=%0d real=%0d required 1/2000", bus.out_valid, bus.out_real);
      end
      #2 rst_n = 1'b0;
      model_reset();
      #1;
      checks++;
      if (bus.out_valid !== 1'b0 || bus.out_real !== 16'sd0 || bus.out_img !== 16'sd0 ||
          bus.out_tw_en !== 1'b0 || bus.out_tw_idx !== 6'd0) begin
         errors++;
         $display("FAIL reset_async valid=%0d real=%0d img=%0d tw_en=%0d idx=%0d required all 0",
                  bus.out_valid, bus.out_real, bus.out_img, bus.out_tw_en, bus.out_tw_idx);
      end
      @(negedge clk);
      rst_n = 1'b1;
      step(1, 1000, 0);
      checks++;
      if (bus.out_valid !== 1'b0 || bus.out_real !== 16'sd0 || bus.out_tw_en !== 1'b1 || bus.out_tw_idx !== 6'd0) begin
         errors++;
         $display("FAIL reset_first valid=%0d real=%0d tw_en=%0d idx=%0d required 0/0/1/0",
                  bus.out_valid, bus.out_real, bus.out_tw_en, bus.out_tw_idx);
      end
      step(1, 2000, 0); step(1, 3000, 0);
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_real !== 16'sd2000) begin
         errors++; $display("FAIL reset_newframe valid=%0d real=%0d required 1/2000", bus.out_valid, bus.out_real);
      end
   endtask

   task automatic test_basic_drain();
      int ins [6] = '{1000, 2000, 3000, 4000, 0, 0};
      int ev  [6] = '{0, 0, 1, 1, 1, 1};
      int er  [6] = '{0, 0, 2000, 3000, -1000, -1000};
      int et  [6] = '{1, 1, 0, 0, 1, 1};
      int ei  [6] = '{0, 16, 0, 0, 0, 16};
      do_reset();
      for (int i = 0; i < 6; i++) begin
         step(1, ins[i], 0);
         checks++;
         if (int'(bus.out_valid) !== ev[i] || int'(bus.out_real) !== er[i] || int'(bus.out_img) !== 0 ||
             int'(bus.out_tw_en) !== et[i] || int'(bus.out_tw_idx) !== ei[i]) begin
            errors++;
            $display("FAIL basic[%0d] got v=%0d re=%0d im=%0d tw=%0d idx=%0d required v=%0d re=%0d im=0 tw=%0d idx=%0d",
                     i, bus.out_valid, bus.out_real, bus.out_img, bus.out_tw_en, bus.out_tw_idx, ev[i], er[i], et[i], ei[i]);
         end
      end
   endtask

   task automatic test_extremes();
      int ire [6] = '{32767, -32768, 32767, -32768, 0, 0};
      int iim [6] = '{-32768, -32768, -32768, -32768, 0, 0};
      int ev  [6] = '{0, 0, 1, 1, 1, 1};
      int er  [6] = '{0, 0, 32767, -32768, 0, 0};
      int em  [6] = '{0, 0, -32768, -32768, 0, 0};
      int et  [6] = '{1, 1, 0, 0, 1, 1};
      int ei  [6] = '{0, 16, 0, 0, 0, 16};
      do_reset();
      for (int i = 0; i < 6; i++) begin
         step(1, ire[i], iim[i]);
         checks++;
         if (int'(bus.out_valid) !== ev[i] || int'(bus.out_real) !== er[i] || int'(bus.out_img) !== em[i] ||
             int'(bus.out_tw_en) !== et[i] || int'(bus.out_tw_idx) !== ei[i]) begin
            errors++;
            $display("FAIL extremes[%0d] got v=%0d re=%0d im=%0d tw=%0d idx=%0d required v=%0d re=%0d im=%0d tw=%0d idx=%0d",
                     i, bus.out_valid, bus.out_real, bus.out_img, bus.out_tw_en, bus.out_tw_idx,
                     ev[i], er[i], em[i], et[i], ei[i]);
         end
      end
   endtask

   task automatic test_stall();
      int iv  [7] = '{1, 1, 0, 0, 0, 1, 1};
      int ins [7] = '{1000, 2000, 0, 0, 0, 3000, 4000};
      int ev  [7] = '{0, 0, 0, 0, 0, 1, 1};
      int er  [7] = '{0, 0, 0, 0, 0, 2000, 3000};
      int et  [7] = '{1, 1, 1, 1, 1, 0, 0};
      int ei  [7] = '{0, 16, 16, 16, 16, 0, 0};
      do_reset();
      for (int i = 0; i < 7; i++) begin
         step(iv[i] != 0, (iv[i] != 0) ? ins[i] : int'($urandom_range(0, 65535)) - 32768, 0);
         checks++;
         if (int'(bus.out_valid) !== ev[i] || int'(bus.out_real) !== er[i] ||
             int'(bus.out_tw_en) !== et[i] || int'(bus.out_tw_idx) !== ei[i]) begin
            errors++;
            $display("FAIL stall[%0d] got v=%0d re=%0d tw=%0d idx=%0d required v=%0d re=%0d tw=%0d idx=%0d",
                     i, bus.out_valid, bus.out_real, bus.out_tw_en, bus.out_tw_idx, ev[i], er[i], et[i], ei[i]);
         end
      end
   endtask

   task automatic test_rounding();
      int ins [6] = '{1, -1, 0, 0, 0, 0};
      int ev  [6] = '{0, 0, 1, 1, 1, 1};
      int er  [6] = '{0, 0, 0, -1, 0, -1};
      int ei  [6] = '{0, 16, 0, 0, 0, 16};
      do_reset();
      for (int i = 0; i < 6; i++) begin
         step(1, ins[i], 0);
         checks++;
         if (int'(bus.out_valid) !== ev[i] || int'(bus.out_real) !== er[i] || int'(bus.out_tw_idx) !== ei[i]) begin
            errors++;
            $display("FAIL rounding[%0d] got v=%0d re=%0d idx=%0d required v=%0d re=%0d idx=%0d",
                     i, bus.out_valid, bus.out_real, bus.out_tw_idx, ev[i], er[i], ei[i]);
         end
      end
   endtask

   task automatic test_random();
      bit v;
      do_reset();
      for (int i = 0; i < 300; i++) begin
         v = ($urandom_range(0, 3) != 0);
         step(v, int'($urandom_range(0, 65535)) - 32768, int'($urandom_range(0, 65535)) - 32768);
         checks++;
         if (int'(bus.out_valid) !== e_valid || int'(bus.out_real) !== e_re || int'(bus.out_img) !== e_im ||
             int'(bus.out_tw_en) !== e_tw || int'(bus.out_tw_idx) !== e_idx) begin
            errors++;
            $display("FAIL random[%0d] got v=%0d re=%0d im=%0d tw=%0d idx=%0d required v=%0d re=%0d im=%0d tw=%0d idx=%0d",
                     i, bus.out_valid, bus.out_real, bus.out_img, bus.out_tw_en, bus.out_tw_idx,
                     e_valid, e_re, e_im, e_tw, e_idx);
         end
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst_n = 1'b0;
      bus.in_valid = 1'b0;
      bus.in_real = '0;
      bus.in_img = '0;
      #1;
      checks++;
      if (bus.out_valid !== 1'b0 || bus.out_real !== 16'sd0 || bus.out_tw_idx !== 6'd0) begin
         errors++; $display("FAIL reset_init valid=%0d real=%0d idx=%0d required 0", bus.out_valid, bus.out_real, bus.out_tw_idx);
      end
      test_reset();
      test_basic_drain();
      test_extremes();
      test_stall();
      test_rounding();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
